sync_fifo_flagged: RTL and testbench

- Parametrised synchronous FIFO that succeeds the original single-port-op FIFO.
- Adds concurrent read+write, any DEPTH (not only powers of two), programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow flags, a synchronous flush, and a first-word-fall-through (FWFT) mode.
- Sits between producer and consumer stages in the same clock domain.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/sync_fifo_flagged_if.sv | 36 +++
 rtl/fifo_wrap_ptr.sv | 37 +++
 rtl/sync_fifo_flagged.sv | 149 ++++++++++++++
 tb/tb_sync_fifo_flagged.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the flagged synchronous FIFO.
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_flagged_if.sv
// Producer/consumer-facing signal bundle of the flagged FIFO.
interface sync_fifo_flagged_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = cnt_width(DEPTH);

  logic             flush;
  logic             clear_flags;
  logic             write;
  logic [WIDTH-1:0] data_in;
  logic             read;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, clear_flags, write, data_in, read,
    input  data_out, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  flush, clear_flags, write, data_in, read,
    output data_out, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer; wraps explicitly so any depth works, not just powers of two.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_flagged.sv
// Synchronous FIFO with count-decoded flags, sticky error flags, flush and optional FWFT read path.
module sync_fifo_flagged
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input logic               clk,
  input logic               reset_n,
  sync_fifo_flagged_if.slave bus
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  if (DEPTH < 2) begin : g_chk_depth
    $error("sync_fifo_flagged: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_afull
    $error("sync_fifo_flagged: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_chk_aempty
    $error("sync_fifo_flagged: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             empty, full;
  logic             wr_ok, rd_ok, wr_en, rd_en;
  fifo_op_e         op;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_ok = bus.write && (!full || bus.read);
  assign rd_ok = bus.read && !empty;
  assign wr_en = wr_ok && !bus.flush;
  assign rd_en = rd_ok && !bus.flush;
  assign op    = fifo_op_e'({rd_en, wr_en});

  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else begin
      case (op)
        OP_PUSH: count_d = count_q + CW'(1);
        OP_POP:  count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // A new error in the same cycle as clear_flags keeps the flag set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (!bus.flush && bus.write && full && !bus.read) begin
      overflow_d = 1'b1;
    end else if (bus.clear_flags) begin
      overflow_d = 1'b0;
    end
    if (!bus.flush && bus.read && empty) begin
      underflow_d = 1'b1;
    end else if (bus.clear_flags) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= bus.data_in;
    end
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.flush),
    .inc     (wr_en),
    .ptr     (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.flush),
    .inc     (rd_en),
    .ptr     (rd_ptr)
  );

  if (FWFT != 0) begin : g_fwft
    assign bus.data_out = empty ? '0 : mem_q[rd_ptr];
    assign bus.rd_valid = !empty;
  end else begin : g_registered
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;

    always_comb begin
      data_out_d = data_out_q;
      rd_valid_d = 1'b0;
      if (rd_en) begin
        data_out_d = mem_q[rd_ptr];
        rd_valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_out_q <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        data_out_q <= data_out_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
  end

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Randomised and directed bench for sync_fifo_flagged, checked against a queue-based reference model.
module tb_sync_fifo_flagged;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flagged_if #(.WIDTH(8), .DEPTH(8)) if0 ();
  sync_fifo_flagged_if #(.WIDTH(8), .DEPTH(5)) if1 ();
  sync_fifo_flagged_if #(.WIDTH(8), .DEPTH(4)) if2 ();

  sync_fifo_flagged #(.WIDTH(8), .DEPTH(8), .FWFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0)
  );
  sync_fifo_flagged #(.WIDTH(8), .DEPTH(5), .FWFT(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1)
  );
  sync_fifo_flagged #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(if2)
  );

  // Per-instance configuration seen by the reference model
  int depth_c [3] = '{8, 5, 4};
  int afth_c  [3] = '{6, 3, 3};
  int aeth_c  [3] = '{2, 2, 1};
  bit fwft_c  [3] = '{1'b0, 1'b0, 1'b1};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct packed {
    logic [7:0] dout;
    logic       rdv;
    logic       emp;
    logic       ful;
    logic       ae;
    logic       af;
    logic       ovf;
    logic       unf;
    logic [3:0] cnt;
  } obs_t;

  function automatic obs_t sample(input int idx);
    obs_t o;
    case (idx)
      0: o = '{if0.data_out, if0.rd_valid, if0.empty, if0.full, if0.almost_empty,
               if0.almost_full, if0.overflow, if0.underflow, 4'(if0.count)};
      1: o = '{if1.data_out, if1.rd_valid, if1.empty, if1.full, if1.almost_empty,
               if1.almost_full, if1.overflow, if1.underflow, 4'(if1.count)};
      default: o = '{if2.data_out, if2.rd_valid, if2.empty, if2.full, if2.almost_empty,
               if2.almost_full, if2.overflow, if2.underflow, 4'(if2.count)};
    endcase
    return o;
  endfunction

  // Reference model: one queue of words per instance plus the sticky flags and last popped word
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  bit         m_ovf  [3];
  bit         m_unf  [3];
  bit         m_rdv  [3];
  logic [7:0] m_dout [3];

  function automatic int qsize(input int idx);
    case (idx)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qfront(input int idx);
    case (idx)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpush(input int idx, input logic [7:0] d);
    case (idx)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic qpop(input int idx, output logic [7:0] d);
    case (idx)
      0: d = q0.pop_front();
      1: d = q1.pop_front();
      default: d = q2.pop_front();
    endcase
  endtask

  task automatic qclear(input int idx);
    case (idx)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      qclear(i);
      m_ovf[i]  = 1'b0;
      m_unf[i]  = 1'b0;
      m_rdv[i]  = 1'b0;
      m_dout[i] = 8'h00;
    end
  endtask

  task automatic modelStep(input int idx, input bit wr, input logic [7:0] din,
                           input bit rd, input bit fl, input bit cf);
    int sz = qsize(idx);
    bit was_full  = (sz == depth_c[idx]);
    bit was_empty = (sz == 0);
    logic [7:0] d;
    m_rdv[idx] = 1'b0;
    if (fl) begin
      qclear(idx);
    end else begin
      if (rd && !was_empty) begin
        qpop(idx, d);
        m_dout[idx] = d;
        m_rdv[idx]  = 1'b1;
      end
      if (wr && (!was_full || rd)) qpush(idx, din);
    end
    if (!fl && wr && was_full && !rd) m_ovf[idx] = 1'b1;
    else if (cf) m_ovf[idx] = 1'b0;
    if (!fl && rd && was_empty) m_unf[idx] = 1'b1;
    else if (cf) m_unf[idx] = 1'b0;
  endtask

  task automatic checkAll(input int idx, input string tag);
    obs_t o = sample(idx);
    int sz = qsize(idx);
    string p = $sformatf("%s[%0d]", tag, idx);
    checkOutput({p, ".count"}, 32'(o.cnt), 32'(sz));
    checkOutput({p, ".empty"}, 32'(o.emp), 32'(sz == 0));
    checkOutput({p, ".full"}, 32'(o.ful), 32'(sz == depth_c[idx]));
    checkOutput({p, ".almost_full"}, 32'(o.af), 32'(sz >= afth_c[idx]));
    checkOutput({p, ".almost_empty"}, 32'(o.ae), 32'(sz <= aeth_c[idx]));
    checkOutput({p, ".overflow"}, 32'(o.ovf), 32'(m_ovf[idx]));
    checkOutput({p, ".underflow"}, 32'(o.unf), 32'(m_unf[idx]));
    if (fwft_c[idx]) begin
      checkOutput({p, ".rd_valid"}, 32'(o.rdv), 32'(sz != 0));
      if (sz != 0) checkOutput({p, ".data_out"}, 32'(o.dout), 32'(qfront(idx)));
    end else begin
      checkOutput({p, ".rd_valid"}, 32'(o.rdv), 32'(m_rdv[idx]));
      checkOutput({p, ".data_out"}, 32'(o.dout), 32'(m_dout[idx]));
    end
  endtask

  task automatic driveIn(input int idx, input bit wr, input logic [7:0] din,
                         input bit rd, input bit fl, input bit cf);
    case (idx)
      0: begin if0.write = wr; if0.data_in = din; if0.read = rd; if0.flush = fl; if0.clear_flags = cf; end
      1: begin if1.write = wr; if1.data_in = din; if1.read = rd; if1.flush = fl; if1.clear_flags = cf; end
      default: begin if2.write = wr; if2.data_in = din; if2.read = rd; if2.flush = fl; if2.clear_flags = cf; end
    endcase
  endtask

  // Drive one cycle at the falling edge, let the DUT clock it, then compare at the next falling edge
  task automatic applyStimulus(input int idx, input bit wr, input logic [7:0] din,
                               input bit rd, input bit fl, input bit cf, input string tag);
    driveIn(idx, wr, din, rd, fl, cf);
    @(posedge clk);
    modelStep(idx, wr, din, rd, fl, cf);
    @(negedge clk);
    driveIn(idx, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkAll(idx, tag);
  endtask

  initial begin
    obs_t o;
    for (int i = 0; i < 3; i++) driveIn(i, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    modelReset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) checkAll(i, "reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Fill depth-8 FIFO, overflow it, drain it, underflow it
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, "fill");
    o = sample(0);
    checkOutput("fill.full_direct", 32'(o.ful), 32'd1);
    checkOutput("fill.count_direct", 32'(o.cnt), 32'd8);
    applyStimulus(0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, "ovf");
    o = sample(0);
    checkOutput("ovf.flag_direct", 32'(o.ovf), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "unf");
    o = sample(0);
    checkOutput("unf.flag_direct", 32'(o.unf), 32'd1);
    checkOutput("unf.dout_held", 32'(o.dout), 32'hA7);
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clrflags");

    // Simultaneous read and write while full
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, "refill");
    applyStimulus(0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, "fullrw");
    o = sample(0);
    checkOutput("fullrw.dout_direct", 32'(o.dout), 32'hA0);
    checkOutput("fullrw.count_direct", 32'(o.cnt), 32'd8);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain2");
    o = sample(0);
    checkOutput("drain2.last_is_B0", 32'(o.dout), 32'hB0);

    // Flush keeps sticky flags; clear_flags then drops them
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, "pre_flush");
    applyStimulus(0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, "pre_flush_ovf");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pre_flush_rd");
    applyStimulus(0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, "flush");
    o = sample(0);
    checkOutput("flush.count_direct", 32'(o.cnt), 32'd0);
    checkOutput("flush.ovf_kept", 32'(o.ovf), 32'd1);
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "post_flush_clr");

    // Depth-5: pointer wrap through concurrent write/read pairs
    for (int i = 0; i < 5; i++) applyStimulus(1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, "d5fill");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "d5rd");
    for (int i = 0; i < 12; i++) applyStimulus(1, 1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0, "d5pair");

    // FWFT: write into empty, then pop and push together
    applyStimulus(2, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "fwft_w");
    o = sample(2);
    checkOutput("fwft_w.dout_direct", 32'(o.dout), 32'h11);
    checkOutput("fwft_w.rdv_direct", 32'(o.rdv), 32'd1);
    applyStimulus(2, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, "fwft_rw");
    o = sample(2);
    checkOutput("fwft_rw.dout_direct", 32'(o.dout), 32'h22);
    checkOutput("fwft_rw.count_direct", 32'(o.cnt), 32'd1);

    // Random traffic on every instance, with occasional flush and flag clears
    for (int idx = 0; idx < 3; idx++) begin
      for (int n = 0; n < 200; n++) begin
        bit wr = ($urandom_range(0, 99) < 55);
        bit rd = ($urandom_range(0, 99) < 50);
        bit fl = ($urandom_range(0, 39) == 0);
        bit cf = ($urandom_range(0, 19) == 0);
        applyStimulus(idx, wr, 8'($urandom), rd, fl, cf, "rand");
      end
    end

    // Asynchronous reset mid-burst, checked before the next rising edge
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, "burst");
    #1 reset_n = 1'b0;
    modelReset();
    #2;
    for (int i = 0; i < 3; i++) checkAll(i, "async_reset");
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, "post_reset_w");
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "post_reset_r");
    o = sample(0);
    checkOutput("post_reset.dout_direct", 32'(o.dout), 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
